// File: rtl/tcm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tcm_pkg
// Brief   : Shared AXI constants and loader FSM encoding for the TCM loader.
// Revision: 1.0
// ============================================================================
package tcm_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_4KB        = 4096;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_AW   = 3'd3;
    localparam logic [2:0] ST_W    = 3'd4;
    localparam logic [2:0] ST_B    = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_WAIT = ST_WAIT,
        S_AW   = ST_AW,
        S_W    = ST_W,
        S_B    = ST_B,
        S_DONE = ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tcm_loader_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tcm_loader_fifo
// Brief   : Synchronous word FIFO with first-word-fall-through head.
// Revision: 1.0
// ============================================================================
module tcm_loader_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tcm_axi_loader.sv
`default_nettype none
// ============================================================================
// Module  : tcm_axi_loader
// Brief   : Word stream to AXI4 INCR write bursts, split at MAX_BURST and 4KB.
// Revision: 1.0
// ============================================================================
module tcm_axi_loader
    import tcm_pkg::*;
#(
    parameter int         MAX_BURST  = 16,
    parameter int         FIFO_DEPTH = 32,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start_i,
    input  logic [31:0] cfg_addr_i,
    input  logic [15:0] cfg_len_i,
    input  logic        s_valid_i,
    input  logic [31:0] s_data_i,
    output logic        s_ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        axi_awvalid_o,
    output logic [31:0] axi_awaddr_o,
    output logic [3:0]  axi_awid_o,
    output logic [7:0]  axi_awlen_o,
    output logic [1:0]  axi_awburst_o,
    input  logic        axi_awready_i,
    output logic        axi_wvalid_o,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    output logic        axi_wlast_o,
    input  logic        axi_wready_i,
    input  logic        axi_bvalid_i,
    input  logic [1:0]  axi_bresp_i,
    input  logic [3:0]  axi_bid_i,
    output logic        axi_bready_o
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t              r_state;
    state_t              w_next_state;
    logic [31:0]         r_addr;
    logic [15:0]         r_words_left;
    logic [15:0]         r_len;
    logic [15:0]         r_accepted;
    logic [8:0]          r_beats;
    logic [8:0]          r_beat;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic [c_CNT_W-1:0]  w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [31:0]         w_fifo_head;
    logic                w_push;
    logic                w_pop;
    logic [12:0]         w_room_bytes;
    logic [10:0]         w_room_words;
    logic [16:0]         w_beats_calc;
    logic [8:0]          w_beats_m1;
    logic                w_last_beat;
    logic                w_unused;

    assign s_ready_o = r_busy && !w_fifo_full && (r_accepted != r_len);
    assign w_push    = s_valid_i && s_ready_o;
    assign w_pop     = axi_wvalid_o && axi_wready_i;

    tcm_loader_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (s_data_i),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Words left before the next 4KB page; addr is word aligned so [1:0] is zero.
    assign w_room_bytes = 13'(AXI_4KB) - {1'b0, r_addr[11:0]};
    assign w_room_words = w_room_bytes[12:2];

    always_comb begin
        w_beats_calc = 17'(MAX_BURST);
        if ({1'b0, r_words_left} < w_beats_calc) begin
            w_beats_calc = {1'b0, r_words_left};
        end
        if ({6'b0, w_room_words} < w_beats_calc) begin
            w_beats_calc = {6'b0, w_room_words};
        end
    end

    assign w_beats_m1  = r_beats - 9'd1;
    assign w_last_beat = (r_beat == w_beats_m1);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_start_i) begin
                    w_next_state = (cfg_len_i == 16'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: w_next_state = S_WAIT;
            S_WAIT: begin
                if (32'(w_fifo_count) >= 32'(r_beats)) begin
                    w_next_state = S_AW;
                end
            end
            S_AW: begin
                if (axi_awready_i) begin
                    w_next_state = S_W;
                end
            end
            S_W: begin
                if (w_pop && w_last_beat) begin
                    w_next_state = S_B;
                end
            end
            S_B: begin
                if (axi_bvalid_i) begin
                    w_next_state = (r_words_left == {7'b0, r_beats}) ? S_DONE : S_CALC;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_words_left <= '0;
            r_len        <= '0;
            r_accepted   <= '0;
            r_beats      <= '0;
            r_beat       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            if (w_push) begin
                r_accepted <= r_accepted + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_start_i) begin
                        r_addr       <= {cfg_addr_i[31:2], 2'b00};
                        r_words_left <= cfg_len_i;
                        r_len        <= cfg_len_i;
                        r_accepted   <= '0;
                        r_error      <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                S_CALC: r_beats <= w_beats_calc[8:0];
                S_AW: begin
                    if (axi_awready_i) begin
                        r_beat <= '0;
                    end
                end
                S_W: begin
                    if (w_pop) begin
                        r_beat <= r_beat + 9'd1;
                    end
                end
                S_B: begin
                    if (axi_bvalid_i) begin
                        r_error      <= r_error | (axi_bresp_i != AXI_RESP_OKAY);
                        r_addr       <= r_addr + {21'b0, r_beats, 2'b00};
                        r_words_left <= r_words_left - {7'b0, r_beats};
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign error_o = r_error;

    // Payload is gated by its valid so every output reads zero while in reset or idle.
    assign axi_awvalid_o = (r_state == S_AW);
    assign axi_awaddr_o  = axi_awvalid_o ? r_addr : 32'd0;
    assign axi_awlen_o   = axi_awvalid_o ? w_beats_m1[7:0] : 8'd0;
    assign axi_awid_o    = axi_awvalid_o ? AXI_ID : 4'd0;
    assign axi_awburst_o = axi_awvalid_o ? AXI_BURST_INCR : 2'b00;
    assign axi_wvalid_o  = (r_state == S_W);
    assign axi_wdata_o   = axi_wvalid_o ? w_fifo_head : 32'd0;
    assign axi_wstrb_o   = axi_wvalid_o ? 4'hF : 4'h0;
    assign axi_wlast_o   = axi_wvalid_o && w_last_beat;
    assign axi_bready_o  = (r_state == S_B);

    assign w_unused = ^{axi_bid_i, cfg_addr_i[1:0], w_room_bytes[1:0],
                        w_beats_calc[16:9], w_beats_m1[8], w_fifo_empty};

endmodule
`default_nettype wire
